// File: rtl/signed_arith_pkg.sv
// Shared definitions for the signed arithmetic blocks.
//   state_t   : sequencing states of the accumulate/hold controller
//   acc_width : accumulator width that cannot overflow for n beats of
//               two w-bit signed operands each
package signed_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Each beat adds two w-bit values (one extra bit), n beats add clog2(n).
  function automatic int acc_width(input int w, input int n);
    return w + 1 + $clog2(n);
  endfunction

endpackage

// File: rtl/signed_accum_adder_if.sv
// Operand/result handshake bundle for signed_accum_adder.
//   in_valid/in_ready : operand beat handshake (a, b, mode)
//   out_valid/out_ready : result handshake (sum, ovf)
//   master : producer/consumer side, slave : the adder
interface signed_accum_adder_if #(
  parameter int W     = 4,
  parameter int OUT_W = W + 1
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [W-1:0]     a;
  logic signed [W-1:0]     b;
  logic                    mode;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] sum;
  logic                    ovf;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, sum, ovf
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, sum, ovf
  );
endinterface

// File: rtl/signed_sat.sv
// Signed narrowing with overflow detect; saturating or wrapping.
//   din  : IN_W-bit signed value (IN_W >= OUT_W)
//   dout : OUT_W-bit result, clamped when SAT != 0, truncated otherwise
//   ovf  : din is not representable in OUT_W bits
module signed_sat #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 5,
  parameter int SAT   = 1
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    ovf
);

  // din fits iff every bit from the output sign bit upward is a copy of it.
  logic [IN_W-OUT_W:0] top;

  assign top = din[IN_W-1:OUT_W-1];
  assign ovf = !((&top) || !(|top));

  always_comb begin
    dout = din[OUT_W-1:0];
    if ((SAT != 0) && ovf) begin
      dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                         : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/signed_accum_adder.sv
// Signed pairwise adder / N-beat accumulator with registered result.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of signed_accum_adder_if (operands in, result out)
//
// state | meaning
// IDLE  | waiting for the first beat of a frame
// ACCUM | accumulate frame in progress, waiting for beats 2..N
// HOLD  | result presented on sum/ovf until consumed
module signed_accum_adder
  import signed_arith_pkg::*;
#(
  parameter int W     = 4,
  parameter int N     = 4,
  parameter int OUT_W = W + 1,
  parameter int SAT   = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  signed_accum_adder_if.slave bus
);

  localparam int ACC_W = acc_width(W, N);
  localparam int CNT_W = $clog2(N + 1);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [OUT_W-1:0] sum_q, sum_d;
  logic                    ovf_q, ovf_d;

  logic                    beat_take;
  logic                    res_take;
  logic                    load_res;
  logic signed [ACC_W-1:0] pair_sum;
  logic signed [OUT_W-1:0] sat_sum;
  logic                    sat_ovf;

  assign beat_take = bus.in_valid && (state_q != HOLD);
  assign res_take  = bus.out_ready && (state_q == HOLD);

  assign pair_sum = {{(ACC_W-W){bus.a[W-1]}}, bus.a}
                  + {{(ACC_W-W){bus.b[W-1]}}, bus.b};

  // Being in ACCUM is itself the latched frame mode, so mode is only
  // looked at in IDLE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (beat_take) begin
          acc_d   = pair_sum;
          cnt_d   = CNT_W'(1);
          state_d = (bus.mode && (N > 1)) ? ACCUM : HOLD;
        end
      end
      ACCUM: begin
        if (beat_take) begin
          acc_d = acc_q + pair_sum;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N - 1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (res_take) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Narrow the next accumulator value so the registered result is ready
  // in the same cycle out_valid rises.
  signed_sat #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W),
    .SAT   (SAT)
  ) u_sat (
    .din  (acc_d),
    .dout (sat_sum),
    .ovf  (sat_ovf)
  );

  assign load_res = (state_d == HOLD) && (state_q != HOLD);

  always_comb begin
    sum_d = sum_q;
    ovf_d = ovf_q;
    if (load_res) begin
      sum_d = sat_sum;
      ovf_d = sat_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.sum       = sum_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_signed_accum_adder.sv
// Bench for signed_accum_adder: a saturating and a wrapping instance
// (W=4, N=4, OUT_W=5) receive identical stimulus; each result is compared
// against frame sums computed with plain integer arithmetic.
module tb_signed_accum_adder;

  logic clk;
  logic rst_n;

  signed_accum_adder_if #(.W(4), .OUT_W(5)) if_s ();
  signed_accum_adder_if #(.W(4), .OUT_W(5)) if_w ();

  signed_accum_adder #(.W(4), .N(4), .OUT_W(5), .SAT(1)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_s)
  );

  signed_accum_adder #(.W(4), .N(4), .OUT_W(5), .SAT(0)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;
  int fa[4];
  int fb[4];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_ovf(input int s);
    return ((s > 15) || (s < -16)) ? 1 : 0;
  endfunction

  function automatic int ref_sat(input int s);
    if (s > 15) return 15;
    if (s < -16) return -16;
    return s;
  endfunction

  function automatic int ref_wrap(input int s);
    int r;
    r = ((s % 32) + 32) % 32;
    if (r >= 16) r -= 32;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int av, input int bv, input bit m);
    logic [3:0] a4, b4;
    a4 = av[3:0];
    b4 = bv[3:0];
    if_s.in_valid = v;  if_w.in_valid = v;
    if_s.a = a4;        if_w.a = a4;
    if_s.b = b4;        if_w.b = b4;
    if_s.mode = m;      if_w.mode = m;
  endtask

  task automatic set_oready(input bit r);
    if_s.out_ready = r;
    if_w.out_ready = r;
  endtask

  task automatic chk_result(input string tag, input int s);
    chk({tag, "_vld"},   int'(if_s.out_valid), 1);
    chk({tag, "_sum_s"}, int'($signed(if_s.sum)), ref_sat(s));
    chk({tag, "_ovf_s"}, int'(if_s.ovf), ref_ovf(s));
    chk({tag, "_vld_w"}, int'(if_w.out_valid), 1);
    chk({tag, "_sum_w"}, int'($signed(if_w.sum)), ref_wrap(s));
    chk({tag, "_ovf_w"}, int'(if_w.ovf), ref_ovf(s));
    chk({tag, "_rdy"},   int'(if_s.in_ready | if_w.in_ready), 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"}, int'(if_s.out_valid | if_w.out_valid), 0);
    chk({tag, "_rdy"}, int'(if_s.in_ready & if_w.in_ready), 1);
  endtask

  // One frame from fa/fb: 1 beat for mode 0, 4 beats for mode 1. Up to
  // max_gap idle cycles precede beats 2..4, with mode scrambled both in
  // gaps and on those beats. The result is then held for `hold` cycles
  // while a beat is offered, and consumed with a beat still offered.
  task automatic run_frame(input string tag, input bit m, input int max_gap,
                           input int hold);
    int nb, s, g;
    nb = m ? 4 : 1;
    s  = 0;
    set_oready(1'b1);
    for (int i = 0; i < nb; i++) begin
      if (i > 0) begin
        g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        for (int k = 0; k < g; k++) begin
          drive(1'b0, fa[i], fb[i], 1'($urandom));
          tick();
          chk_idle({tag, "_gap"});
        end
      end
      drive(1'b1, fa[i], fb[i], (i == 0) ? m : 1'($urandom));
      chk({tag, "_accept_rdy"}, int'(if_s.in_ready & if_w.in_ready), 1);
      tick();
      s += fa[i] + fb[i];
      if (i < nb - 1) chk_idle({tag, "_mid"});
    end
    drive(1'b0, 0, 0, 1'b0);
    chk_result(tag, s);
    set_oready(1'b0);
    for (int k = 0; k < hold; k++) begin
      drive(1'b1, 3, 3, 1'b0);
      tick();
      chk_result({tag, "_hold"}, s);
    end
    drive(1'b1, 1, 1, 1'b0);
    set_oready(1'b1);
    tick();
    chk_idle({tag, "_cons"});
    drive(1'b0, 0, 0, 1'b0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_vld"}, int'(if_s.out_valid | if_w.out_valid), 0);
    chk({tag, "_sum_s"}, int'($signed(if_s.sum)), 0);
    chk({tag, "_sum_w"}, int'($signed(if_w.sum)), 0);
    chk({tag, "_ovf"}, int'(if_s.ovf | if_w.ovf), 0);
  endtask

  task automatic fill(input int a0, input int b0, input int a1, input int b1,
                      input int a2, input int b2, input int a3, input int b3);
    fa[0] = a0; fb[0] = b0; fa[1] = a1; fb[1] = b1;
    fa[2] = a2; fb[2] = b2; fa[3] = a3; fb[3] = b3;
  endtask

  int pa[5] = '{3, -4, 7, -5, 6};
  int pb[5] = '{2, 1, -2, -3, 3};

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 1'b0);
    set_oready(1'b1);
    tick();
    tick();
    chk_reset("reset");
    rst_n = 1'b1;
    tick();
    chk_idle("post_reset");

    // Pairwise vectors.
    for (int i = 0; i < 5; i++) begin
      fill(pa[i], pb[i], 0, 0, 0, 0, 0, 0);
      run_frame("pair", 1'b0, 0, 0);
    end

    // Accumulate vectors, including both overflow directions.
    fill(1, 2, -3, 0, 4, 4, -1, -1);
    run_frame("acc_basic", 1'b1, 0, 0);
    fill(7, 7, 7, 7, 7, 7, 7, 7);
    run_frame("acc_pos_ovf", 1'b1, 0, 0);
    fill(-8, -8, -8, -8, -8, -8, -8, -8);
    run_frame("acc_neg_ovf", 1'b1, 0, 0);

    // Back-pressure in HOLD.
    fill(5, 6, 0, 0, 0, 0, 0, 0);
    run_frame("hold_pair", 1'b0, 0, 3);
    fill(2, 3, -1, 4, 6, -7, 3, 3);
    run_frame("hold_acc", 1'b1, 0, 3);

    // Gaps with mode toggling inside an accumulate frame.
    fill(-2, 5, 3, 3, -8, 1, 7, -4);
    run_frame("gap_acc", 1'b1, 3, 0);

    // Reset after two accumulated beats discards them.
    drive(1'b1, 7, 7, 1'b1);
    tick();
    drive(1'b1, 7, 7, 1'b0);
    tick();
    drive(1'b0, 0, 0, 1'b0);
    rst_n = 1'b0;
    tick();
    chk_reset("rst_mid");
    rst_n = 1'b1;
    chk_idle("rst_mid_rel");
    fill(1, 1, 1, 1, 1, 1, 1, 1);
    run_frame("after_rst", 1'b1, 0, 0);

    // Reset while a result is pending produces no output.
    set_oready(1'b0);
    drive(1'b1, 7, 7, 1'b0);
    tick();
    drive(1'b0, 0, 0, 1'b0);
    chk({"rst_hold_pre"}, int'(if_s.out_valid & if_w.out_valid), 1);
    rst_n = 1'b0;
    tick();
    chk_reset("rst_hold");
    rst_n = 1'b1;
    tick();
    chk_idle("rst_hold_rel");

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 4; i++) begin
        fa[i] = int'($urandom_range(0, 15)) - 8;
        fb[i] = int'($urandom_range(0, 15)) - 8;
      end
      run_frame("rand", 1'($urandom), 2, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/signed_accum_adder.md
SIGNED_ACCUM_ADDER -- requirements
Module: signed_accum_adder

Interface
REQ-001 Parameter W, default 4: operand width in bits, two's complement; legal range 2..32.
REQ-002 Parameter N, default 4: beats per accumulation frame; legal range 1..256.
REQ-003 Parameter OUT_W, default W+1: result width; legal range W+1..W+1+clog2(N).
REQ-004 Parameter SAT, default 1: 1 = saturate result to OUT_W, 0 = wrap (truncate).
REQ-005 clk  input  1  rising-edge clock; single clock domain.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  1  operand beat offered.
REQ-008 in_ready  output  1  block accepts beat this cycle.
REQ-009 a, b  input  W each  signed operands.
REQ-010 mode  input  1  0 = pairwise add, 1 = accumulate N beats; sampled on first beat of a frame only.
REQ-011 out_valid  output  1  result held on sum/ovf.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 sum  output  OUT_W  signed result.
REQ-014 ovf  output  1  full-precision result not representable in OUT_W.

Function
REQ-015 A beat SHALL be accepted when in_valid && in_ready at a rising edge; a result SHALL be consumed when out_valid && out_ready.
REQ-016 The FSM SHALL have states IDLE, ACCUM, HOLD; in_ready = 1 in IDLE/ACCUM, 0 in HOLD; out_valid = 1 only in HOLD.
REQ-017 IDLE, beat accepted, mode=0: acc <= sext(a)+sext(b), -> HOLD.
REQ-018 IDLE, beat accepted, mode=1: acc <= sext(a)+sext(b), cnt <= 1, frame mode latched; -> HOLD if N==1, else -> ACCUM.
REQ-019 ACCUM, beat accepted: acc <= acc+sext(a)+sext(b), cnt <= cnt+1; -> HOLD when the accepted beat is beat N; mode input ignored.
REQ-020 ACCUM, no beat: state, acc, cnt SHALL hold (gaps of any length allowed).
REQ-021 HOLD: sum/ovf SHALL be stable until consumed; on consume -> IDLE; no same-cycle acceptance of a new beat.
REQ-022 Latency: out_valid SHALL rise on the cycle following acceptance of the frame's last beat.
REQ-023 Internal acc SHALL be ACC_W = W+1+clog2(N) bits so it never overflows.
REQ-024 ovf = 1 iff acc outside [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-025 SAT=1: on ovf, sum = most positive or most negative OUT_W value by sign of acc; SAT=0: sum = acc[OUT_W-1:0].
REQ-026 sum and ovf SHALL be registered outputs, not combinational from a/b.

Reset
REQ-027 While rst_n=0 at a clock edge: state <= IDLE, acc <= 0, cnt <= 0, sum <= 0, ovf <= 0, out_valid <= 0.
REQ-028 in_ready SHALL be 1 in the first cycle after reset release.
REQ-029 Reset mid-frame or in HOLD SHALL discard the partial/pending result with no output produced.

Structure
REQ-030 State encoding (IDLE/ACCUM/HOLD) and the ACC_W width function SHALL live in shared package signed_arith_pkg.
REQ-031 Saturation/overflow logic SHALL be one combinational sub-module, signed_sat, parametrised by input and output width, reusable by other arithmetic blocks.

Verification (W=4, N=4, OUT_W=5, SAT=1 unless stated)
REQ-032 Pairwise, out_ready=1: (3,2),(-4,1),(7,-2),(-5,-3),(6,3) -> sum 5,-3,5,-8,9, ovf=0, each one cycle after acceptance.
REQ-033 Accumulate (1,2),(-3,0),(4,4),(-1,-1) -> single result sum=6, ovf=0, out_valid one cycle after 4th beat.
REQ-034 Accumulate (7,7)x4 -> sum=15, ovf=1; (-8,-8)x4 -> sum=-16, ovf=1; repeat with SAT=0 -> sum=-8 (56 wrapped), sum=0 (-64 wrapped), ovf=1.
REQ-035 out_ready=0 for 3 cycles in HOLD -> sum/ovf/out_valid stable, in_ready=0, no beats accepted; consume -> IDLE next cycle.
REQ-036 Accumulate 2 beats, then rst_n=0 one cycle -> out_valid=0, sum=0, next frame (1,1)x4 -> sum=8 unaffected by discarded beats.
REQ-037 Mode toggled during ACCUM with in_valid gaps -> result still 4-beat accumulate sum.
